// File: rtl/dm_wait_responder_if.sv
// Data-memory port bundle between the CPU (master) and a memory responder (slave).
interface dm_wait_responder_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       req_addr;
    logic              req_re;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              stall;
    logic              err;

    modport master (
        output req_addr, req_re, req_we, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, stall, err
    );

    modport slave (
        input  req_addr, req_re, req_we, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, stall, err
    );
endinterface

// File: rtl/dm_wait_responder.sv
// Fixed-latency data-memory responder: one transaction at a time, IDLE -> WAIT -> RESP,
// with a combinational stall so the CPU holds its PC until the response cycle.
module dm_wait_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dm_wait_responder_if.slave    bus
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [3:0]          cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                we_r;
    logic                err_flag_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                err_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                accept_s;
    logic                ready_s;
    logic                stall_s;
    logic [ADDR_W-1:0]   rsp_addr_s;
    logic                rsp_we_s;
    logic [DATA_W-1:0]   rsp_wdata_s;
    logic                rsp_err_s;
    logic                unused_addr_s;

    // Upper address bits are deliberately dropped so addresses alias modulo the depth.
    assign unused_addr_s = ^bus.req_addr[15:ADDR_W];

    // Next-state decode; the rsp_* selects feed the response registers, which must use
    // live request inputs when LATENCY=1 jumps straight from IDLE to RESP.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        ready_s      = 1'b0;
        stall_s      = 1'b0;
        rsp_addr_s   = addr_r;
        rsp_we_s     = we_r;
        rsp_wdata_s  = wdata_r;
        rsp_err_s    = err_flag_r;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (bus.req_re || bus.req_we) begin
                    accept_s    = 1'b1;
                    stall_s     = 1'b1;
                    rsp_addr_s  = bus.req_addr[ADDR_W-1:0];
                    rsp_we_s    = bus.req_we;
                    rsp_wdata_s = bus.req_wdata;
                    rsp_err_s   = bus.req_re & bus.req_we;
                    if (LATENCY == 1) begin
                        next_state_s = RESP;
                    end else begin
                        next_state_s = WAIT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                stall_s = 1'b1;
                if (cnt_r <= 4'd1) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, latency counter and captured request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= '0;
            wdata_r    <= '0;
            we_r       <= 1'b0;
            err_flag_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cnt_r      <= CNT_LOAD;
                addr_r     <= bus.req_addr[ADDR_W-1:0];
                wdata_r    <= bus.req_wdata;
                we_r       <= bus.req_we;
                err_flag_r <= bus.req_re & bus.req_we;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Response registers load on the edge entering RESP; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            err_r       <= 1'b0;
        end else begin
            rsp_valid_r <= (next_state_s == RESP);
            err_r       <= (next_state_s == RESP) && rsp_err_s;
            if (next_state_s == RESP) begin
                rsp_rdata_r <= rsp_we_s ? rsp_wdata_s : mem_r[rsp_addr_s];
            end
        end
    end

    // Write commits on the edge ending RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if ((state_r == RESP) && we_r && !rst) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.stall     = stall_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.err       = err_r;

endmodule
